clk_speed_detect: RTL and testbench
===================================

CLK_SPEED_DETECT -- requirements
Module: clk_speed_detect

Interface
REQ-001 SHALL have parameter N, default 12500000: base half-period unit in CLK_in cycles; nominal half-period for speed code k (k=0..3) is T_k = (k+1)*N+1.
REQ-002 SHALL have parameter TOL, default 1000: match tolerance in cycles; TOL < N/2 and 4N+1+TOL < 2^32.
REQ-003 SHALL have port CLK_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Sig_in, input, 1 bit: asynchronous toggling signal whose half-period encodes a 2-bit speed code.
REQ-006 SHALL have port Sp_out, output, 2 bits: decoded speed code; meaningful only while Valid=1.
REQ-007 SHALL have port Valid, output, 1 bit: high while locked to one speed code.
REQ-008 SHALL have port Timeout, output, 1 bit: high after a missing-edge timeout, until the next detected edge.
REQ-009 SHALL have port Half_period, output, 32 bits: last measured edge-to-edge interval in CLK_in cycles.

Function
REQ-010 SHALL synchronize Sig_in through two flops plus one history flop; an edge (either polarity) is detected when the last two stages differ, 3 cycles after the Sig_in change.
REQ-011 SHALL keep a 32-bit counter cnt: cleared on a detected edge, otherwise incremented, saturating at TLIM = 4N+1+TOL.
REQ-012 SHALL, on a detected edge outside IDLE, register Half_period = cnt+1; edges P cycles apart yield Half_period = P.
REQ-013 SHALL classify measured P as match k iff T_k-TOL <= P <= T_k+TOL (inclusive, unsigned); at most one k matches; otherwise no-match.
REQ-014 SHALL implement FSM states IDLE, ARMED, LOCK, plus a 3-bit candidate register (valid bit + code).
REQ-015 IDLE: first detected edge -> ARMED, clear cnt and candidate; Half_period unchanged.
REQ-016 ARMED, edge: match k equal to valid candidate -> LOCK, Sp_out=k, Valid=1; match k otherwise -> candidate=k, stay; no-match -> clear candidate, stay.
REQ-017 LOCK, edge: match k == Sp_out -> stay; match other k -> ARMED, candidate=k, Valid=0; no-match -> ARMED, candidate cleared, Valid=0.
REQ-018 ARMED or LOCK with cnt == TLIM and no edge that cycle -> IDLE, Valid=0, Timeout=1, candidate cleared.
REQ-019 Edge in the same cycle as cnt == TLIM: edge SHALL take priority; no timeout.
REQ-020 Timeout SHALL clear on the cycle after the next detected edge.
REQ-021 All outputs SHALL be registered; Valid, Sp_out, Half_period update one cycle after the edge-detect cycle.
REQ-022 Sp_out SHALL hold its last value when Valid drops.

Reset
REQ-023 RST=1 SHALL immediately force state IDLE, cnt=0, candidate cleared, synchronizer flops 0, Sp_out=0, Valid=0, Timeout=0, Half_period=0.
REQ-024 Reset asserted mid-lock SHALL discard the lock; relock requires the full IDLE->ARMED->LOCK sequence (three edges).

Verification (N=10, TOL=2; T = 11/21/31/41, TLIM=43)
REQ-025 Sig_in toggling every 11 cycles -> after 3rd edge: Half_period=11, Sp_out=00, Valid=1; remains locked.
REQ-026 Lock at 31-cycle toggle (Sp_out=10), switch to 21 -> Valid=0 after first 21-cycle edge, Sp_out=01 and Valid=1 after second.
REQ-027 Intervals 9 and 13 -> match code 00; intervals 8 and 14 -> no-match, Valid stays/drops to 0, Half_period=8/14.
REQ-028 Locked, then Sig_in held constant -> Valid=0, Timeout=1 one cycle after cnt reaches 43; next edge -> Timeout=0, state ARMED.
REQ-029 Edge arriving exactly at cnt==43 -> no timeout, Half_period=44, no-match -> ARMED.
REQ-030 RST pulsed while locked (mid-cycle, between clock edges) -> all outputs 0 immediately; Valid returns only after three further edges.

Source files
------------

// File: rtl/clk_speed_detect.sv
// clk_speed_detect: measures the edge-to-edge interval of an asynchronous
// toggling input and decodes it into a 2-bit speed code. A code is reported
// as Valid only after two consecutive intervals agree on it. A missing edge
// for longer than the slowest nominal half-period plus tolerance drops lock
// and raises Timeout.
module clk_speed_detect #(
    parameter int unsigned N   = 12500000,
    parameter int unsigned TOL = 1000
) (
    input  logic        CLK_in,
    input  logic        RST,
    input  logic        Sig_in,
    output logic [1:0]  Sp_out,
    output logic        Valid,
    output logic        Timeout,
    output logic [31:0] Half_period
);

    // Counter saturation point: longest acceptable half-period
    localparam logic [31:0] TLIM = 32'(4 * N + 1 + TOL);

    typedef enum logic [1:0] {IDLE, ARMED, LOCK} state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  cand_q, cand_d;      // {valid, code}
    logic [1:0]  sp_q, sp_d;
    logic        valid_q, valid_d;
    logic        tout_q, tout_d;
    logic [31:0] hp_q, hp_d;

    logic        edge_det;
    logic [31:0] p_meas;
    logic        match_hit;
    logic [1:0]  match_code;
    logic [31:0] t_nom;

    assign edge_det = s2_q ^ s3_q;
    assign p_meas   = cnt_q + 32'd1;

    // Classify the interval that ends at this edge against the four windows
    always_comb begin
        match_hit  = 1'b0;
        match_code = 2'd0;
        t_nom      = 32'd0;
        for (int k = 0; k < 4; k++) begin
            t_nom = 32'((k + 1) * N + 1);
            if (p_meas >= t_nom - TOL && p_meas <= t_nom + TOL) begin
                match_hit  = 1'b1;
                match_code = k[1:0];
            end
        end
    end

    // Next-state: synchronizer, interval counter and lock FSM
    always_comb begin
        s1_d    = Sig_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        state_d = state_q;
        cand_d  = cand_q;
        sp_d    = sp_q;
        valid_d = valid_q;
        tout_d  = tout_q;
        hp_d    = hp_q;

        if (edge_det)
            cnt_d = 32'd0;
        else if (cnt_q == TLIM)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 32'd1;

        // Any detected edge ends a timeout indication
        if (edge_det)
            tout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // First edge only starts a measurement; no interval yet
                if (edge_det) begin
                    state_d = ARMED;
                    cand_d  = 3'b000;
                end
            end
            ARMED: begin
                if (edge_det) begin
                    hp_d = p_meas;
                    if (match_hit && cand_q[2] && cand_q[1:0] == match_code) begin
                        state_d = LOCK;
                        sp_d    = match_code;
                        valid_d = 1'b1;
                    end else if (match_hit) begin
                        cand_d = {1'b1, match_code};
                    end else begin
                        cand_d = 3'b000;
                    end
                end else if (cnt_q == TLIM) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                    cand_d  = 3'b000;
                end
            end
            LOCK: begin
                if (edge_det) begin
                    hp_d = p_meas;
                    if (!(match_hit && match_code == sp_q)) begin
                        // Sp_out keeps the old code while unlocked
                        state_d = ARMED;
                        valid_d = 1'b0;
                        cand_d  = match_hit ? {1'b1, match_code} : 3'b000;
                    end
                end else if (cnt_q == TLIM) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                    cand_d  = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                cand_d  = 3'b000;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK_in or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= 32'd0;
            cand_q  <= 3'b000;
            sp_q    <= 2'd0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            hp_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            sp_q    <= sp_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            hp_q    <= hp_d;
        end
    end

    assign Sp_out      = sp_q;
    assign Valid       = valid_q;
    assign Timeout     = tout_q;
    assign Half_period = hp_q;

endmodule

// File: tb/tb_clk_speed_detect.sv
// tb_clk_speed_detect: directed vectors for clk_speed_detect with N=10, TOL=2
// (nominal half-periods 11/21/31/41, counter limit 43).
module tb_clk_speed_detect;

    logic        CLK_in;
    logic        RST;
    logic        Sig_in;
    logic [1:0]  Sp_out;
    logic        Valid;
    logic        Timeout;
    logic [31:0] Half_period;

    int n_vec;
    int n_err;

    clk_speed_detect #(.N(10), .TOL(2)) dut (
        .CLK_in      (CLK_in),
        .RST         (RST),
        .Sig_in      (Sig_in),
        .Sp_out      (Sp_out),
        .Valid       (Valid),
        .Timeout     (Timeout),
        .Half_period (Half_period)
    );

    initial CLK_in = 1'b0;
    always #5 CLK_in = ~CLK_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int sp, input int to, input int hp);
        chk({tag, ".valid"},   32'(Valid),   32'(v));
        chk({tag, ".sp"},      32'(Sp_out),  32'(sp));
        chk({tag, ".timeout"}, 32'(Timeout), 32'(to));
        chk({tag, ".hp"},      Half_period,  32'(hp));
    endtask

    task automatic tick();
        @(posedge CLK_in);
        #1;
    endtask

    // Toggle Sig_in p cycles after the previous toggle, then advance to the
    // point where that edge's outputs are visible (3 cycles after toggle).
    task automatic step(input int p);
        repeat (p - 3) tick();
        Sig_in = ~Sig_in;
        repeat (3) tick();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        RST    = 1'b1;
        Sig_in = 1'b0;
        repeat (2) tick();
        chk_out("reset", 0, 0, 0, 0);
        RST = 1'b0;
        repeat (3) tick();

        // Lock at 11-cycle half-period
        step(5);  chk_out("arm11",   0, 0, 0, 0);
        step(11); chk_out("cand11",  0, 0, 0, 11);
        step(11); chk_out("lock11",  1, 0, 0, 11);
        step(11); chk_out("hold11",  1, 0, 0, 11);

        // Move to 31, then switch to 21
        step(31); chk_out("drop31",  0, 0, 0, 31);
        step(31); chk_out("lock31",  1, 2, 0, 31);
        step(21); chk_out("drop21",  0, 2, 0, 21);
        step(21); chk_out("lock21",  1, 1, 0, 21);

        // Tolerance boundaries around 11
        step(9);  chk_out("tol9",    0, 1, 0, 9);
        step(13); chk_out("tol13",   1, 0, 0, 13);
        step(8);  chk_out("miss8",   0, 0, 0, 8);
        step(14); chk_out("miss14",  0, 0, 0, 14);
        step(11); chk_out("re11a",   0, 0, 0, 11);
        step(11); chk_out("re11b",   1, 0, 0, 11);

        // Timeout: cnt reaches 43 after 43 further cycles
        repeat (43) tick();
        chk_out("pre_to",  1, 0, 0, 11);
        tick();
        chk_out("timeout", 0, 0, 1, 11);
        repeat (10) tick();
        chk_out("to_hold", 0, 0, 1, 11);
        step(3);  chk_out("to_clr",  0, 0, 0, 11);
        step(11); chk_out("arm_a",   0, 0, 0, 11);
        step(11); chk_out("arm_b",   1, 0, 0, 11);

        // Edge arriving exactly at cnt==43
        step(44); chk_out("edge_lim", 0, 0, 0, 44);
        step(11); chk_out("lim_a",    0, 0, 0, 11);
        step(11); chk_out("lim_b",    1, 0, 0, 11);

        // Reset mid-cycle while locked
        #2;
        RST = 1'b1;
        #1;
        chk_out("rst_now", 0, 0, 0, 0);
        Sig_in = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        repeat (3) tick();
        step(5);  chk_out("rl_arm",  0, 0, 0, 0);
        step(11); chk_out("rl_cand", 0, 0, 0, 11);
        step(11); chk_out("rl_lock", 1, 0, 0, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
